exp_eu: RTL and testbench

Pipelined exponent unit that computes y = e^x for one signed Q(W-Q).Q value per cycle. It is the requester side of the shared exponent coefficient LUT used by the GELU/softmax datapath. Each instance converts x to base 2, drives one LUT port with a 3-bit segment index, and applies the returned slope/intercept pair as a piecewise-linear 2^v approximation. It then shifts the result by the integer exponent. Up to NUM_PORTS instances share one LUT.

---
 rtl/exp_eu_if.sv | 25 ++
 rtl/exp_eu.sv | 97 +++++++++
 tb/tb_exp_eu.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exp_eu_if.sv
// Stream and LUT-port bundle for the pipelined exponent unit.
// The unit takes the slave modport; the LUT/stream side takes master.
interface exp_eu_if #(
  parameter int unsigned W = 32
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x_in;
  logic [2:0]   seg_idx;
  logic [W-1:0] k_coeff;
  logic [W-1:0] b_intercept;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y_out;

  modport master (
    output in_valid, x_in, k_coeff, b_intercept, out_ready,
    input  in_ready, seg_idx, out_valid, y_out
  );

  modport slave (
    input  in_valid, x_in, k_coeff, b_intercept, out_ready,
    output in_ready, seg_idx, out_valid, y_out
  );
endinterface

// File: rtl/exp_eu.sv
// Three-stage y = e^x unit: base-2 conversion, piecewise-linear 2^v from a
// shared LUT port, then an integer-exponent shift with saturation.
module exp_eu #(
  parameter int unsigned Q     = 26,
  parameter int unsigned W     = 32,
  parameter logic [W-1:0] LOG2E = 32'h05C551D9
) (
  input logic   clk,
  input logic   rst,
  exp_eu_if.slave bus
);
  localparam int unsigned PW = 2 * W;
  localparam logic [W-1:0] SAT = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] U_SAT = W'(5);
  localparam logic signed [W-1:0] U_MIN = -$signed(W'(Q + 1));

  logic en;

  logic                s1_valid;
  logic signed [W-1:0] u1;
  logic [Q-1:0]        v1;

  logic                s2_valid;
  logic signed [W-1:0] u2;
  logic [W-1:0]        p2;

  logic signed [PW-1:0] prod1_c;
  logic signed [PW-1:0] z_c;
  logic signed [W-1:0]  u1_c;
  logic [Q-1:0]         v1_c;
  logic signed [PW-1:0] vx_c;
  logic signed [PW-1:0] prod2_c;
  logic [W-1:0]         p_c;
  logic [PW-1:0]        wide_c;
  logic [W-1:0]         neg_c;
  logic [W-1:0]         y_c;

  // One global enable: the whole pipe freezes while the output is held.
  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  // S1: z = x*log2(e) in Q, split into floor integer u and fraction v.
  assign prod1_c = PW'($signed(bus.x_in)) * PW'($signed(LOG2E));
  assign z_c     = prod1_c >>> Q;
  assign u1_c    = W'(z_c >>> Q);
  assign v1_c    = z_c[Q-1:0];

  // S2: chord evaluation with the LUT pair selected by the registered seg_idx.
  assign vx_c    = $signed(PW'(v1));
  assign prod2_c = PW'($signed(bus.k_coeff)) * vx_c;
  assign p_c     = W'(prod2_c >>> Q) + bus.b_intercept;

  // S3: scale 2^v in [1,2) by 2^u, saturating high and flushing to zero low.
  always_comb begin
    y_c    = '0;
    wide_c = '0;
    neg_c  = -u2;
    if (u2 >= U_SAT) begin
      y_c = SAT;
    end else if (!u2[W-1]) begin
      wide_c = PW'(p2) << u2;
      y_c    = (wide_c > PW'(SAT)) ? SAT : wide_c[W-1:0];
    end else if (u2 >= U_MIN) begin
      y_c = p2 >> neg_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s2_valid      <= 1'b0;
      bus.out_valid <= 1'b0;
      u1            <= '0;
      v1            <= '0;
      u2            <= '0;
      p2            <= '0;
      bus.seg_idx   <= '0;
      bus.y_out     <= '0;
    end else if (en) begin
      s1_valid      <= bus.in_valid;
      s2_valid      <= s1_valid;
      bus.out_valid <= s2_valid;
      if (bus.in_valid) begin
        u1          <= u1_c;
        v1          <= v1_c;
        bus.seg_idx <= v1_c[Q-1:Q-3];
      end
      if (s1_valid) begin
        u2 <= u1;
        p2 <= p_c;
      end
      if (s2_valid) begin
        bus.y_out <= y_c;
      end
    end
  end
endmodule

// File: tb/tb_exp_eu.sv
// Scoreboard bench for exp_eu with a chord-interpolation 2^v LUT model
// driven combinationally from seg_idx.
module tb_exp_eu;
  logic clk;
  logic rst;

  exp_eu_if #(.W(32)) bus ();

  exp_eu #(.Q(26), .W(32), .LOG2E(32'h05C551D9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int lut_k [8];
  int lut_b [8];

  assign bus.k_coeff     = lut_k[bus.seg_idx];
  assign bus.b_intercept = lut_b[bus.seg_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] exp_q [$];

  function automatic logic [31:0] model(input logic [31:0] x);
    longint z, u, v, k, b, p;
    z = (longint'($signed(x)) * 64'sd96817625) >>> 26;
    u = z >>> 26;
    v = z & 64'sh3FFFFFF;
    k = longint'(lut_k[int'(v >>> 23)]);
    b = longint'(lut_b[int'(v >>> 23)]);
    p = ((k * v) >>> 26) + b;
    if (u >= 5) return 32'h7FFFFFFF;
    if (u >= 0) begin
      p = p <<< u;
      return (p > 64'sh7FFFFFFF) ? 32'h7FFFFFFF : 32'(p);
    end
    if (u >= -27) return 32'(p >>> (-u));
    return 32'h0;
  endfunction

  // Drive one cycle's inputs at the falling edge and sample settled outputs.
  task automatic step(input bit iv, input logic [31:0] x, input bit ordy,
                      output bit rdy, output bit ov, output logic [31:0] y,
                      output logic [2:0] sg);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.x_in      = x;
    bus.out_ready = ordy;
    #1;
    rdy = bus.in_ready;
    ov  = bus.out_valid;
    y   = bus.y_out;
    sg  = bus.seg_idx;
  endtask

  task automatic test_reset();
    vectors += 4;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    if (bus.y_out !== 32'h0) begin errors++; $display("FAIL reset_y_out got %h want 0", bus.y_out); end
    if (bus.seg_idx !== 3'd0) begin errors++; $display("FAIL reset_seg_idx got %0d want 0", bus.seg_idx); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] dx [4];
    logic [31:0] dy [4];
    logic [2:0]  ds [4];
    bit rdy, ov, seen;
    logic [31:0] y, e;
    logic [2:0] sg;
    real yr;
    dx = '{32'h00000000, 32'hFC000000, 32'h10000000, 32'hA0000000};
    dy = '{32'h04000000, 32'h0, 32'h7FFFFFFF, 32'h00000000};
    ds = '{3'd0, 3'd4, 3'd6, 3'd3};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, dx[i], 1'b1, rdy, ov, y, sg);
      vectors++;
      if (rdy !== 1'b1) begin errors++; $display("FAIL directed_ready[%0d] got %b want 1", i, rdy); end
      else exp_q.push_back(model(dx[i]));
      seen = 1'b0;
      for (int n = 1; n <= 8 && !seen; n++) begin
        step(1'b0, 32'h0, 1'b1, rdy, ov, y, sg);
        if (n == 1) begin
          vectors++;
          if (sg !== ds[i]) begin errors++; $display("FAIL directed_seg[%0d] got %0d want %0d", i, sg, ds[i]); end
        end
        if (ov) begin
          seen = 1'b1;
          vectors += 2;
          if (n != 3) begin errors++; $display("FAIL directed_latency[%0d] got %0d want 3", i, n); end
          if (exp_q.size() == 0) begin errors++; $display("FAIL directed_extra[%0d] got %h want none", i, y); end
          else begin
            e = exp_q.pop_front();
            if (y !== e) begin errors++; $display("FAIL directed_model[%0d] got %h want %h", i, y, e); end
          end
          vectors++;
          if (i == 1) begin
            yr = real'(y) / 67108864.0;
            if ((yr - $exp(-1.0) > 1.0 / 1024.0) || ($exp(-1.0) - yr > 1.0 / 1024.0)) begin
              errors++; $display("FAIL directed_e_inv got %f want %f", yr, $exp(-1.0));
            end
          end else if (y !== dy[i]) begin
            errors++; $display("FAIL directed_value[%0d] got %h want %h", i, y, dy[i]);
          end
        end
      end
      if (!seen) begin vectors++; errors++; $display("FAIL directed_timeout[%0d] got none want result", i); end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 1153;
    bit rdy, ov;
    logic [31:0] y, x, e;
    logic [2:0] sg;
    logic [7:0] seg_seen;
    int outs, first, last;
    seg_seen = '0; outs = 0; first = -1; last = -1;
    for (int i = 0; i < N + 10; i++) begin
      x = 32'hC0000000 + (32'(i) << 20);
      step(i < N, x, 1'b1, rdy, ov, y, sg);
      seg_seen[sg] = 1'b1;
      if (i < N) begin
        vectors++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL sweep_ready[%0d] got %b want 1", i, rdy); end
        else exp_q.push_back(model(x));
      end
      if (ov) begin
        if (first < 0) first = i;
        last = i;
        outs++;
        vectors++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL sweep_extra got %h want none", y); end
        else begin
          e = exp_q.pop_front();
          if (y !== e) begin errors++; $display("FAIL sweep_value[%0d] got %h want %h", outs - 1, y, e); end
        end
      end
    end
    vectors += 4;
    if (outs != N) begin errors++; $display("FAIL sweep_count got %0d want %0d", outs, N); end
    if (last - first != N - 1) begin errors++; $display("FAIL sweep_throughput got %0d want %0d", last - first, N - 1); end
    if (seg_seen !== 8'hFF) begin errors++; $display("FAIL sweep_seg_cover got %b want 11111111", seg_seen); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL sweep_leftover got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    bit rdy, ov, ordy, prev_stall;
    logic [31:0] y, x, e, prev_y;
    logic [2:0] sg;
    prev_stall = 1'b0; prev_y = '0;
    for (int i = 0; i < 400; i++) begin
      x    = $urandom;
      ordy = 1'($urandom_range(0, 1));
      step(1'b1, x, ordy, rdy, ov, y, sg);
      vectors++;
      if (rdy !== !(ov && !ordy)) begin errors++; $display("FAIL stall_ready[%0d] got %b want %b", i, rdy, !(ov && !ordy)); end
      if (prev_stall) begin
        vectors++;
        if (ov !== 1'b1 || y !== prev_y) begin
          errors++; $display("FAIL stall_hold[%0d] got %b/%h want 1/%h", i, ov, y, prev_y);
        end
      end
      if (rdy) exp_q.push_back(model(x));
      if (ov && ordy) begin
        vectors++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL stall_extra got %h want none", y); end
        else begin
          e = exp_q.pop_front();
          if (y !== e) begin errors++; $display("FAIL stall_value[%0d] got %h want %h", i, y, e); end
        end
      end
      prev_stall = ov && !ordy;
      prev_y     = y;
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 32'h0, 1'b1, rdy, ov, y, sg);
      if (ov) begin
        vectors++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL stall_drain_extra got %h want none", y); end
        else begin
          e = exp_q.pop_front();
          if (y !== e) begin errors++; $display("FAIL stall_drain_value got %h want %h", y, e); end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stall_lost got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_midstream();
    bit rdy, ov, seen;
    logic [31:0] y, e;
    logic [2:0] sg;
    for (int i = 0; i < 3; i++) step(1'b1, 32'h04000000 + 32'(i), 1'b1, rdy, ov, y, sg);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors += 4;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", bus.out_valid); end
    if (bus.y_out !== 32'h0) begin errors++; $display("FAIL midrst_y_out got %h want 0", bus.y_out); end
    if (bus.seg_idx !== 3'd0) begin errors++; $display("FAIL midrst_seg_idx got %0d want 0", bus.seg_idx); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); end
    exp_q.delete();
    step(1'b1, 32'h02000000, 1'b1, rdy, ov, y, sg);
    exp_q.push_back(model(32'h02000000));
    seen = 1'b0;
    for (int n = 1; n <= 8 && !seen; n++) begin
      step(1'b0, 32'h0, 1'b1, rdy, ov, y, sg);
      if (ov) begin
        seen = 1'b1;
        e = exp_q.pop_front();
        vectors += 2;
        if (n != 3) begin errors++; $display("FAIL midrst_latency got %0d want 3", n); end
        if (y !== e) begin errors++; $display("FAIL midrst_value got %h want %h", y, e); end
      end
    end
    if (!seen) begin vectors++; errors++; $display("FAIL midrst_timeout got none want result"); end
  endtask

  initial begin
    real kr, br;
    for (int i = 0; i < 8; i++) begin
      kr = 8.0 * ($pow(2.0, real'(i + 1) / 8.0) - $pow(2.0, real'(i) / 8.0));
      br = $pow(2.0, real'(i) / 8.0) - kr * real'(i) / 8.0;
      lut_k[i] = $rtoi(kr * 67108864.0);
      lut_b[i] = $rtoi(br * 67108864.0);
    end
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
